// File: rtl/mem_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arb
//  Description : N-port memory bus arbiter with a word-addressed backing
//                memory. Serves one read/write at a time with a fixed access
//                latency; round-robin or fixed-priority arbitration; sticky
//                error flags for illegal commands, bad addresses and
//                requests that change while being served.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arb #(
  parameter int NPORTS    = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 65536,
  parameter int LATENCY   = 100,
  parameter int RR_EN     = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [2*NPORTS-1:0]                           rw_req,
  input  logic [ADDR_W*NPORTS-1:0]                      addr_req,
  input  logic [DATA_W*NPORTS-1:0]                      wdata_req,
  output logic [DATA_W-1:0]                             rdata,
  output logic [NPORTS-1:0]                             rd_done,
  output logic [NPORTS-1:0]                             wb_done,
  output logic                                          busy,
  output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] grant_id,
  output logic [2:0]                                    err
);

  localparam int                c_GID_W     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int                c_IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [7:0]        c_LAT       = 8'(LATENCY);
  localparam logic [ADDR_W:0]   c_MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [1:0]        c_CMD_RD    = 2'b01;
  localparam logic [1:0]        c_CMD_WR    = 2'b10;
  localparam logic [1:0]        c_CMD_BAD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          counter_q, counter_d;
  logic [c_GID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [c_GID_W-1:0]  grant_q, grant_d;
  logic [1:0]          rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                oob_q, oob_d;
  logic [2:0]          err_q, err_d;
  logic [NPORTS-1:0]   rd_done_q, rd_done_d;
  logic [NPORTS-1:0]   wb_done_q, wb_done_d;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [MEM_WORDS];

  logic [NPORTS-1:0]   w_cand;
  logic [NPORTS-1:0]   w_illegal;
  logic                w_found;
  logic                w_hi_found;
  logic [c_GID_W-1:0]  w_hi_win;
  logic [c_GID_W-1:0]  w_lo_win;
  logic [c_GID_W-1:0]  w_winner;
  logic [1:0]          w_win_rw;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic [1:0]          w_g_rw;
  logic [ADDR_W-1:0]   w_g_addr;
  logic [NPORTS-1:0]   w_g_onehot;
  logic                w_commit;
  logic [c_IDX_W-1:0]  w_mem_idx;

  assign w_mem_idx = addr_q[c_IDX_W-1:0];

  // Classify each port's command: legal request, or the reserved 2'b11 code
  always_comb begin
    w_cand    = '0;
    w_illegal = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_cand[i]    = (rw_req[2*i +: 2] == c_CMD_RD) || (rw_req[2*i +: 2] == c_CMD_WR);
      w_illegal[i] = (rw_req[2*i +: 2] == c_CMD_BAD);
    end
  end

  // Pick a winner: first candidate above rr_ptr, else wrap to the lowest one
  always_comb begin
    w_found    = 1'b0;
    w_hi_found = 1'b0;
    w_hi_win   = '0;
    w_lo_win   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found  = 1'b1;
        w_lo_win = c_GID_W'(i);
      end
      if (w_cand[i] && (c_GID_W'(i) > rr_ptr_q)) begin
        w_hi_found = 1'b1;
        w_hi_win   = c_GID_W'(i);
      end
    end
    w_winner = ((RR_EN != 0) && w_hi_found) ? w_hi_win : w_lo_win;
  end

  // Route the winner's and the granted port's request fields
  always_comb begin
    w_win_rw    = '0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_g_rw      = '0;
    w_g_addr    = '0;
    w_g_onehot  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (c_GID_W'(i) == w_winner) begin
        w_win_rw    = rw_req[2*i +: 2];
        w_win_addr  = addr_req[ADDR_W*i +: ADDR_W];
        w_win_wdata = wdata_req[DATA_W*i +: DATA_W];
      end
      if (c_GID_W'(i) == grant_q) begin
        w_g_rw        = rw_req[2*i +: 2];
        w_g_addr      = addr_req[ADDR_W*i +: ADDR_W];
        w_g_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, latency countdown in ACCESS
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oob_d     = oob_q;
    err_d     = err_q;
    rd_done_d = '0;
    wb_done_d = '0;
    w_commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|w_illegal) begin
          err_d[0] = 1'b1;
        end
        if (w_found) begin
          rw_d      = w_win_rw;
          addr_d    = w_win_addr;
          wdata_d   = w_win_wdata;
          grant_d   = w_winner;
          counter_d = c_LAT;
          oob_d     = ({1'b0, w_win_addr} >= c_MEM_LIMIT);
          if ({1'b0, w_win_addr} >= c_MEM_LIMIT) begin
            err_d[1] = 1'b1;
          end
          if (RR_EN != 0) begin
            rr_ptr_d = w_winner;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // The master must hold its request until it sees the done pulse
        if ((w_g_rw != rw_q) || (w_g_addr != addr_q)) begin
          err_d[2] = 1'b1;
        end
        if (counter_q != 8'd0) begin
          counter_d = counter_q - 8'd1;
        end else begin
          w_commit = 1'b1;
          if (rw_q == c_CMD_RD) begin
            rd_done_d = w_g_onehot;
          end else begin
            wb_done_d = w_g_onehot;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      rr_ptr_q  <= c_GID_W'(NPORTS - 1);
      grant_q   <= '0;
      rw_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      oob_q     <= 1'b0;
      err_q     <= '0;
      rd_done_q <= '0;
      wb_done_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oob_q     <= oob_d;
      err_q     <= err_d;
      rd_done_q <= rd_done_d;
      wb_done_q <= wb_done_d;
    end
  end

  // Memory array: contents survive reset; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (!reset && w_commit && (rw_q == c_CMD_WR) && !oob_q) begin
      mem_q[w_mem_idx] <= wdata_q;
    end
  end

  // Read data register: only changes when a read completes
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (w_commit && (rw_q == c_CMD_RD)) begin
      rdata_q <= oob_q ? '0 : mem_q[w_mem_idx];
    end
  end

  assign rdata    = rdata_q;
  assign rd_done  = rd_done_q;
  assign wb_done  = wb_done_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arb
//  Description : Self-checking bench for mem_bus_arb. Instance A: 2 ports,
//                latency 4, round-robin, 256 words. Instance B: 4 ports,
//                latency 0, fixed priority, 256 words, random rounds checked
//                against a memory/arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arb;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance A ----------------
  logic        a_rst;
  logic [3:0]  a_rw;
  logic [31:0] a_addr;
  logic [31:0] a_wd;
  logic [15:0] a_rdata;
  logic [1:0]  a_rd_done, a_wb_done;
  logic        a_busy;
  logic [0:0]  a_gid;
  logic [2:0]  a_err;

  mem_bus_arb #(.NPORTS(2), .ADDR_W(16), .DATA_W(16), .MEM_WORDS(256),
                .LATENCY(4), .RR_EN(1)) u_a (
    .clk(clk), .reset(a_rst), .rw_req(a_rw), .addr_req(a_addr),
    .wdata_req(a_wd), .rdata(a_rdata), .rd_done(a_rd_done),
    .wb_done(a_wb_done), .busy(a_busy), .grant_id(a_gid), .err(a_err)
  );

  // ---------------- instance B ----------------
  logic        b_rst;
  logic [7:0]  b_rw;
  logic [63:0] b_addr;
  logic [63:0] b_wd;
  logic [15:0] b_rdata;
  logic [3:0]  b_rd_done, b_wb_done;
  logic        b_busy;
  logic [1:0]  b_gid;
  logic [2:0]  b_err;

  mem_bus_arb #(.NPORTS(4), .ADDR_W(16), .DATA_W(16), .MEM_WORDS(256),
                .LATENCY(0), .RR_EN(0)) u_b (
    .clk(clk), .reset(b_rst), .rw_req(b_rw), .addr_req(b_addr),
    .wdata_req(b_wd), .rdata(b_rdata), .rd_done(b_rd_done),
    .wb_done(b_wb_done), .busy(b_busy), .grant_id(b_gid), .err(b_err)
  );

  // Model state for instance B: memory image of words 0..15 and sticky errors
  logic [15:0] m_mem [16];
  logic [2:0]  m_err;
  logic [1:0]  r_op   [4];
  logic [15:0] r_addr [4];
  logic [15:0] r_wd   [4];

  typedef struct {
    int          port;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any done pulse on A; n = edges elapsed, -1 on timeout
  task automatic a_wait(output int n, output logic [1:0] rd, output logic [1:0] wb);
    n = -1; rd = '0; wb = '0;
    for (int c = 1; c <= 40 && n < 0; c++) begin
      tick();
      if ((a_rd_done | a_wb_done) != 2'b00) begin
        n = c; rd = a_rd_done; wb = a_wb_done;
      end
    end
  endtask

  // One complete transaction on A from an idle bus
  task automatic a_txn(input int p, input logic [1:0] op, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd);
    int n; logic [1:0] rd, wb;
    a_rw[2*p +: 2] = op; a_addr[16*p +: 16] = addr; a_wd[16*p +: 16] = wd;
    a_wait(n, rd, wb);
    chk("a_latency", n, 6);
    chk("a_rd_done", rd, (op == RD) ? (2'b01 << p) : 2'b00);
    chk("a_wb_done", wb, (op == WR) ? (2'b01 << p) : 2'b00);
    chk("a_grant_id", a_gid, p);
    if (op == RD) chk("a_rdata", a_rdata, exp_rd);
    a_rw[2*p +: 2] = 2'b00;
    tick();
    chk("a_pulse_width", {a_rd_done, a_wb_done}, 0);
  endtask

  // One round on B: all ports present r_op at once; model serves legal
  // requests lowest index first, each master dropping after its done pulse
  task automatic b_round(input bit gap_chk);
    int order[$]; int n, last, q, c; logic [15:0] e;
    for (int p = 0; p < 4; p++) begin
      if (r_op[p] == RD || r_op[p] == WR) order.push_back(p);
      if (r_op[p] == 2'b11) m_err[0] = 1'b1;
      b_rw[2*p +: 2] = r_op[p]; b_addr[16*p +: 16] = r_addr[p]; b_wd[16*p +: 16] = r_wd[p];
    end
    n = 0; last = 0;
    foreach (order[i]) begin
      q = order[i]; c = 0;
      do begin tick(); n++; c++; end
      while (c < 20 && (b_rd_done | b_wb_done) == 4'b0000);
      chk("b_rd_done", b_rd_done, (r_op[q] == RD) ? (4'b0001 << q) : 4'b0000);
      chk("b_wb_done", b_wb_done, (r_op[q] == WR) ? (4'b0001 << q) : 4'b0000);
      chk("b_grant_id", b_gid, q);
      if (r_op[q] == RD) begin
        e = (r_addr[q] < 16'd256) ? m_mem[r_addr[q][3:0]] : 16'h0000;
        chk("b_rdata", b_rdata, e);
      end
      if (r_addr[q] >= 16'd256) m_err[1] = 1'b1;
      else if (r_op[q] == WR) m_mem[r_addr[q][3:0]] = r_wd[q];
      if (gap_chk) chk((i == 0) ? "b_first_latency" : "b_spacing", n - last, (i == 0) ? 2 : 3);
      last = n;
      b_rw[2*q +: 2] = 2'b00;
    end
    b_rw = '0;
    tick(); tick();
    chk("b_err", b_err, m_err);
    chk("b_busy_idle", b_busy, 0);
  endtask

  initial begin
    int n, k, restore, x, a;
    logic [1:0] rd, wb;

    tbl[0] = '{0, WR, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1] = '{0, RD, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[2] = '{1, WR, 16'h00FF, 16'h1234, 16'h0000};
    tbl[3] = '{0, RD, 16'h00FF, 16'h0000, 16'h1234};
    tbl[4] = '{1, RD, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[5] = '{0, WR, 16'h0005, 16'h5555, 16'h0000};
    tbl[6] = '{1, RD, 16'h0005, 16'h0000, 16'h5555};

    a_rst = 1'b1; a_rw = '0; a_addr = '0; a_wd = '0;
    b_rst = 1'b1; b_rw = '0; b_addr = '0; b_wd = '0;
    m_err = '0;
    repeat (3) tick();
    a_rst = 1'b0; b_rst = 1'b0;
    chk("a_reset_rdata", a_rdata, 0);
    chk("a_reset_done", {a_rd_done, a_wb_done}, 0);
    chk("a_reset_busy", a_busy, 0);
    chk("a_reset_gid", a_gid, 0);
    chk("a_reset_err", a_err, 0);
    chk("b_reset_state", {b_rdata, b_rd_done, b_wb_done, b_busy, b_gid, b_err}, 0);

    // A: table of single transactions
    for (int i = 0; i < 7; i++) begin
      a_txn(tbl[i].port, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd);
      chk("a_err_clean", a_err, 0);
    end

    // A: round-robin contention, each port drops for one cycle after done
    a_addr = {16'h00FF, 16'h0010}; a_rw = {RD, RD}; restore = -1; k = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      tick();
      if (restore >= 0) begin a_rw[2*restore +: 2] = RD; restore = -1; end
      if ((a_rd_done | a_wb_done) != 2'b00) begin
        chk("a_rr_order", a_rd_done, 2'b01 << (k % 2));
        chk("a_rr_gid", a_gid, k % 2);
        chk("a_rr_rdata", a_rdata, (k % 2 == 0) ? 16'hBEEF : 16'h1234);
        restore = a_rd_done[1] ? 1 : 0;
        a_rw[2*restore +: 2] = 2'b00;
        k++;
      end
    end
    chk("a_rr_count", k, 4);
    a_rw = '0; tick(); tick();

    // A: reset while a write is in flight at counter=2
    a_rw[1:0] = WR; a_addr[15:0] = 16'h0005; a_wd[15:0] = 16'hAAAA;
    repeat (3) tick();
    chk("a_busy_in_access", a_busy, 1);
    a_rst = 1'b1; a_rw = '0;
    tick();
    a_rst = 1'b0;
    chk("a_midrst_outputs", {a_rdata, a_rd_done, a_wb_done, a_busy, a_gid, a_err}, 0);
    k = 0;
    repeat (10) begin tick(); if ((a_rd_done | a_wb_done) != 2'b00) k++; end
    chk("a_midrst_no_done", k, 0);
    a_txn(0, RD, 16'h0005, 16'h0000, 16'h5555);

    // A: error flags
    a_txn(0, RD, 16'h0100, 16'h0000, 16'h0000);
    chk("a_err_oob", a_err, 3'b010);
    a_rw = 4'b1100;
    repeat (4) tick();
    chk("a_illegal_no_grant", a_busy, 0);
    chk("a_err_illegal", a_err, 3'b011);
    a_rw = '0; tick();
    a_rw[1:0] = RD; a_addr[15:0] = 16'h0010;
    repeat (3) tick();
    a_addr[15:0] = 16'h0011;
    a_wait(n, rd, wb);
    chk("a_proto_done", rd, 2'b01);
    chk("a_proto_rdata", a_rdata, 16'hBEEF);
    chk("a_err_proto", a_err, 3'b111);
    a_rw = '0; tick();

    // B: preload words 0..15; first round all four ports at once
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        r_op[p] = WR; r_addr[p] = 16'(4*r + p); r_wd[p] = 16'($urandom);
      end
      b_round(r == 0);
    end
    // B: all four ports read distinct addresses
    for (int p = 0; p < 4; p++) begin
      r_op[p] = RD; r_addr[p] = 16'(p + 8); r_wd[p] = '0;
    end
    b_round(1'b1);

    // B: fixed priority starves port 1 while port 0 keeps re-requesting
    b_rw = {4'b0000, RD, RD}; b_addr = '0; b_addr[31:16] = 16'h0001;
    restore = -1; k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      tick();
      if (restore >= 0) begin b_rw[1:0] = RD; restore = -1; end
      if ((b_rd_done | b_wb_done) != 4'b0000) begin
        chk("b_starve_winner", b_rd_done, 4'b0001);
        b_rw[1:0] = 2'b00; restore = 0; k++;
      end
    end
    chk("b_starve_count", k, 4);
    b_rw[1:0] = 2'b00;
    k = 0;
    for (int c = 0; c < 20 && k == 0; c++) begin
      tick();
      if (b_rd_done != 4'b0000) begin
        k = 1;
        chk("b_port1_served", b_rd_done, 4'b0010);
        chk("b_port1_rdata", b_rdata, m_mem[1]);
      end
    end
    chk("b_port1_seen", k, 1);
    b_rw = '0; tick(); tick();

    // B: random rounds against the model
    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < 4; p++) begin
        x = int'($urandom_range(0, 9));
        r_op[p] = (x < 3) ? 2'b00 : (x < 6) ? RD : (x < 9) ? WR : 2'b11;
        a = int'($urandom_range(0, 19));
        r_addr[p] = (a < 16) ? 16'(a) : 16'(256 + a - 16);
        r_wd[p] = 16'($urandom);
      end
      b_round(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
